sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Serial-in/parallel-out receiver: the far end of the team's PISO shift register link.
//   Shifts in one bit per enabled clock and assembles WIDTH-bit words.
//   Presents each completed word on a valid/ready output holding register.
//   Sits between the serial link pins and the parallel consumer logic.
// PARAMETERS
//   WIDTH      4   bits per word (>= 2)
//   MSB_FIRST  1   1: first received bit lands in pout[WIDTH-1]; 0: first bit lands in pout[0]
// PORTS
//   clk          in   1      single clock; all state updates on the rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   din          in   1      serial data bit
//   din_en       in   1      din is sampled this cycle
//   sync         in   1      word alignment marker (see BEHAVIOUR)
//   pout         out  WIDTH  assembled word (holding register)
//   pout_valid   out  1      pout holds an unconsumed word
//   pout_ready   in   1      consumer accepts the word this cycle
//   overrun      out  1      sticky: a completed word was dropped
//   clr_overrun  in   1      synchronous clear of overrun
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous):
//   - shift reg=0, bit count=0, pout=0, pout_valid=0, overrun=0.
//   - Reset mid-word discards the partial word.
//   Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
//   Shift, MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
//   - The shift happens only when din_en=1.
//   Bit counter: 0..WIDTH-1.
//   - Increments on each din_en.
//   - Wraps to 0 at the edge that samples the WIDTH-th bit; no idle gap is needed between words.
//   Word completion: the edge sampling the last bit, with the counter at WIDTH-1.
//   - The completed word is the shifted value including that bit.
//   - If the holding register is free, or being freed this cycle: pout <= word and pout_valid <= 1
//     at that same edge. Latency is 0 cycles after the last-bit edge.
//   Handshake: transfer occurs when pout_valid & pout_ready.
//   - Transfer with no completion: pout_valid <= 0 and pout keeps its value.
//   - Transfer and completion in the same cycle: new word loaded, pout_valid stays 1.
//   - pout_ready while pout_valid=0 is ignored.
//   Overrun: completion while pout_valid=1 and pout_ready=0.
//   - The new word is dropped and pout is unchanged.
//   - overrun <= 1 and stays set until clr_overrun.
//   - If clr_overrun and a new overrun occur in the same cycle, set wins.
//   sync with din_en=1: the bit is treated as bit 0 of a new word.
//   - Partial word discarded; counter <= 1; sr loaded with that bit as the first bit.
//   - When WIDTH=2 that bit is not a completion.
//   sync with din_en=0: counter <= 0, partial word discarded, sr unchanged.
//   sync never affects pout, pout_valid or overrun.
//   din_en=0 and sync=0: all shift/count state holds.
// STRUCTURE
//   Shared package sipo_pkg:
//   - localparam DEF_WIDTH=4.
//   - Function clog2_w(width) for the counter width.
//   Sub-module sipo_bit_counter (WIDTH):
//   - Inputs en, clr, load1; outputs cnt and last (= en & cnt==WIDTH-1).
//   - Top level holds the shift register, the holding register and the overrun flag.
// TESTING
//   Bench configuration: WIDTH=4, MSB_FIRST=1 unless stated; 10-time-unit clock period.
//   T1 Reset: reset_n=0 mid-word with din_en toggling
//      -> pout=0000, pout_valid=0, overrun=0; the next 4 bits form a clean word.
//   T2 Basic: pout_ready=1, din_en=1, bits 1,1,0,1
//      -> pout=1101 and pout_valid=1 after the 4th edge; pout_valid=0 the following edge.
//   T3 LSB-first: MSB_FIRST=0, bits 1,0,0,0 -> pout=0001.
//   T4 Back-to-back: 0101 then 1000 streamed continuously, pout_ready=1 throughout
//      -> two pout_valid pulses 4 cycles apart.
//   T5 Overrun: pout_ready=0, send 0111 then 1111
//      -> pout stays 0111 and overrun=1; clr_overrun -> overrun=0.
//   T6 Sync: send 1,0 then sync=1 with din=1, then 0,1,0
//      -> pout=1010; the partial word is discarded.
//   T7 Gaps: bits 1,0,1,0 with idle cycles between them -> pout=1010.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out receiver.
// clog2_w sizes the bit counter and never returns less than 1.
package sipo_pkg;

  localparam int DEF_WIDTH = 4;

  function automatic int clog2_w(input int width);
    int r;
    r = 1;
    while ((1 << r) < width) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit position within the current word; last flags the edge that samples the final bit.
// Zero latency on last; load1 (re-sync with a bit) beats clr, which beats en.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW = clog2_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  input  logic          load1,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load1) begin
      cnt_d = CW'(1);
    end else if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words into a valid/ready holding register.
// Word appears at the last-bit edge; if the holder is full and not drained, the word is dropped and overrun latches.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_en,
  input  logic             sync,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = clog2_w(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, shifted, first_bit;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic [CW-1:0]    cnt_unused;
  logic             last;

  // A sync pulse takes precedence over normal counting, so completion is only possible without sync.
  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (din_en & ~sync),
    .clr     (sync & ~din_en),
    .load1   (sync & din_en),
    .cnt     (cnt_unused),
    .last    (last)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted   = {sr_q[WIDTH-2:0], din};
      assign first_bit = {{(WIDTH-1){1'b0}}, din};
    end else begin : g_lsb
      assign shifted   = {din, sr_q[WIDTH-1:1]};
      assign first_bit = {din, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (sync) begin
      if (din_en) sr_d = first_bit;
    end else if (din_en) begin
      sr_d = shifted;
    end
  end

  // Overrun set is applied after the clear so a simultaneous set wins.
  always_comb begin
    pout_d = pout_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (last) begin
      if (!vld_q || pout_ready) begin
        pout_d = shifted;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && pout_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q   <= '0;
      pout_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      pout_q <= pout_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = vld_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n, din, din_en, sync, pout_ready, clr_overrun;
  logic [W-1:0] pout_m, pout_l;
  logic vld_m, vld_l, ovr_m, ovr_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .din(din), .din_en(din_en), .sync(sync),
    .pout(pout_m), .pout_valid(vld_m), .pout_ready(pout_ready),
    .overrun(ovr_m), .clr_overrun(clr_overrun)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .din(din), .din_en(din_en), .sync(sync),
    .pout(pout_l), .pout_valid(vld_l), .pout_ready(pout_ready),
    .overrun(ovr_l), .clr_overrun(clr_overrun)
  );

  // Reference model: a queue of bits received since the word start; index 0 = msb, 1 = lsb config.
  bit           q[$];
  logic [W-1:0] e_pout[2];
  bit           e_vld[2];
  bit           e_ovr[2];

  function automatic void model_reset();
    q.delete();
    for (int m = 0; m < 2; m++) begin
      e_pout[m] = '0;
      e_vld[m]  = 1'b0;
      e_ovr[m]  = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit           done;
    bit           drop;
    logic [W-1:0] w[2];
    done = 1'b0;
    w[0] = '0;
    w[1] = '0;
    if (sync) begin
      q.delete();
      if (din_en) q.push_back(din);
    end else if (din_en) begin
      q.push_back(din);
      if (q.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          w[0][W-1-i] = q[i];
          w[1][i]     = q[i];
        end
        q.delete();
      end
    end
    for (int m = 0; m < 2; m++) begin
      drop = done && e_vld[m] && !pout_ready;
      if (done && !drop) begin
        e_pout[m] = w[m];
        e_vld[m]  = 1'b1;
      end else if (!done && e_vld[m] && pout_ready) begin
        e_vld[m] = 1'b0;
      end
      e_ovr[m] = drop ? 1'b1 : (clr_overrun ? 1'b0 : e_ovr[m]);
    end
  endfunction

  task automatic cyc(input bit d, input bit en, input bit s, input bit r, input bit c);
    din = d; din_en = en; sync = s; pout_ready = r; clr_overrun = c;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic send_bits(input logic [W-1:0] b, input bit r);
    for (int i = W - 1; i >= 0; i--) cyc(b[i], 1'b1, 1'b0, r, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; din = 0; din_en = 0; sync = 0; pout_ready = 0; clr_overrun = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({pout_m, vld_m, ovr_m, pout_l, vld_l, ovr_l} !== '0) begin
      bad++;
      $display("FAIL reset_state: got m=%b/%b/%b l=%b/%b/%b want all zero", pout_m, vld_m, ovr_m, pout_l, vld_l, ovr_l);
    end
    reset_n = 1'b1;
    send_bits(4'b0110, 1'b0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({pout_m, vld_m, ovr_m} !== 6'b0) begin
      bad++;
      $display("FAIL reset_async: got pout=%b vld=%b ovr=%b want 0000/0/0", pout_m, vld_m, ovr_m);
    end
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    reset_n = 1'b1;
    send_bits(4'b1011, 1'b0);
    total++;
    if ({pout_m, vld_m, pout_l, vld_l} !== {4'b1011, 1'b1, 4'b1101, 1'b1}) begin
      bad++;
      $display("FAIL reset_clean_word: got m=%b/%b l=%b/%b want 1011/1 1101/1", pout_m, vld_m, pout_l, vld_l);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_basic();
    logic [W-1:0] b;
    b = 4'b1101;
    for (int i = W - 1; i >= 0; i--) begin
      cyc(b[i], 1'b1, 1'b0, 1'b1, 1'b0);
      if (i > 0) begin
        total++;
        if (vld_m !== 1'b0) begin
          bad++;
          $display("FAIL basic_early_valid: bit %0d got vld=%b want 0", W - 1 - i, vld_m);
        end
      end
    end
    total++;
    if ({pout_m, vld_m} !== {4'b1101, 1'b1}) begin
      bad++;
      $display("FAIL basic_word: got %b/%b want 1101/1", pout_m, vld_m);
    end
    idle(1, 1'b1);
    total++;
    if ({pout_m, vld_m} !== {4'b1101, 1'b0}) begin
      bad++;
      $display("FAIL basic_drain: got %b/%b want 1101/0", pout_m, vld_m);
    end
  endtask

  task automatic test_lsb_first();
    send_bits(4'b1000, 1'b1);
    total++;
    if ({pout_l, vld_l, pout_m} !== {4'b0001, 1'b1, 4'b1000}) begin
      bad++;
      $display("FAIL lsb_first: got l=%b/%b m=%b want 0001/1 1000", pout_l, vld_l, pout_m);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream;
    int pulses, first_at, second_at;
    stream = 8'b0101_1000;
    pulses = 0; first_at = -1; second_at = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) cyc(stream[7-c], 1'b1, 1'b0, 1'b1, 1'b0);
      else idle(1, 1'b1);
      if (vld_m) begin
        pulses++;
        if (first_at < 0) first_at = c;
        else second_at = c;
        total++;
        if (pout_m !== ((c == 3) ? 4'b0101 : 4'b1000)) begin
          bad++;
          $display("FAIL b2b_word: cycle %0d got %b", c, pout_m);
        end
      end
    end
    total++;
    if (pulses != 2 || first_at != 3 || second_at != 7) begin
      bad++;
      $display("FAIL b2b_pulses: got n=%0d at %0d,%0d want 2 at 3,7", pulses, first_at, second_at);
    end
  endtask

  task automatic test_overrun();
    send_bits(4'b0111, 1'b0);
    total++;
    if ({pout_m, vld_m, ovr_m} !== {4'b0111, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ovr_first: got %b/%b/%b want 0111/1/0", pout_m, vld_m, ovr_m);
    end
    send_bits(4'b1111, 1'b0);
    total++;
    if ({pout_m, vld_m, ovr_m, ovr_l} !== {4'b0111, 1'b1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ovr_set: got %b/%b/%b l=%b want 0111/1/1 1", pout_m, vld_m, ovr_m, ovr_l);
    end
    cyc(0, 0, 0, 0, 1);
    total++;
    if ({ovr_m, vld_m} !== 2'b01) begin
      bad++;
      $display("FAIL ovr_clear: got ovr=%b vld=%b want 0/1", ovr_m, vld_m);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    total++;
    if ({pout_m, ovr_m} !== {4'b0111, 1'b1}) begin
      bad++;
      $display("FAIL ovr_set_wins: got pout=%b ovr=%b want 0111/1", pout_m, ovr_m);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    total++;
    if ({pout_m, vld_m, ovr_m} !== {4'b0010, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL xfer_and_load: got %b/%b/%b want 0010/1/0", pout_m, vld_m, ovr_m);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_sync();
    cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    total++;
    if (vld_m !== 1'b0) begin
      bad++;
      $display("FAIL sync_no_early_word: got vld=%b want 0", vld_m);
    end
    cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    total++;
    if ({pout_m, vld_m} !== {4'b1010, 1'b1}) begin
      bad++;
      $display("FAIL sync_word: got %b/%b want 1010/1", pout_m, vld_m);
    end
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    total++;
    if ({pout_m, vld_m} !== {4'b1010, 1'b1}) begin
      bad++;
      $display("FAIL sync_holds_output: got %b/%b want 1010/1", pout_m, vld_m);
    end
    idle(1, 1'b1);
    send_bits(4'b0011, 1'b1);
    total++;
    if ({pout_m, vld_m, ovr_m} !== {4'b0011, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sync_noen_word: got %b/%b/%b want 0011/1/0", pout_m, vld_m, ovr_m);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_gaps();
    logic [W-1:0] b;
    b = 4'b1010;
    for (int i = W - 1; i >= 0; i--) begin
      cyc(b[i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (i > 0) idle($urandom_range(1, 3), 1'b0);
    end
    total++;
    if ({pout_m, vld_m, pout_l} !== {4'b1010, 1'b1, 4'b0101}) begin
      bad++;
      $display("FAIL gaps_word: got m=%b/%b l=%b want 1010/1 0101", pout_m, vld_m, pout_l);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
          $urandom_range(0, 1), $urandom_range(0, 19) == 0);
      total++;
      if ({pout_m, vld_m, ovr_m} !== {e_pout[0], e_vld[0], e_ovr[0]}) begin
        bad++;
        $display("FAIL rand_msb: cycle %0d got %b/%b/%b want %b/%b/%b", c, pout_m, vld_m, ovr_m,
                 e_pout[0], e_vld[0], e_ovr[0]);
      end
      total++;
      if ({pout_l, vld_l, ovr_l} !== {e_pout[1], e_vld[1], e_ovr[1]}) begin
        bad++;
        $display("FAIL rand_lsb: cycle %0d got %b/%b/%b want %b/%b/%b", c, pout_l, vld_l, ovr_l,
                 e_pout[1], e_vld[1], e_ovr[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_overrun();
    test_sync();
    test_gaps();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
